// File: rtl/ldstr_queue_ctrl.sv
// Load/store reservation queue control.
// Circular-buffer allocator over DEPTH entries. It drives one-hot write, clear
// and load-data strobes into the RS entries. A head-of-queue FSM owns the
// data-memory handshake.
//
// Ports:
//   clk, flush              clock; synchronous active-high reset / pipeline flush
//   alloc / alloc_tag       dispatch request, tag of the written entry (= tail)
//   full, empty, count      occupancy state
//   squash, squash_tag      roll back to squash_tag (youngest survivor)
//   head_ready, head_is_load  head entry status
//   head_tag, head_done     head pointer, head memory access complete
//   retire                  pop head (ignored unless head_done)
//   dmem_req/read/resp      data-memory handshake
//   issue_we/clr/ld_mem_val per-entry strobes (combinational, same cycle)
//
// Memory FSM:
//   state | meaning
//   IDLE  | no access outstanding; wait for a ready head
//   REQ   | request held to dmem for the head entry
//   DONE  | head access finished; waiting for retire
//   DRAIN | flush hit an in-flight access; swallow its response
module ldstr_queue_ctrl #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             flush,
  input  logic             alloc,
  output logic [PTR_W-1:0] alloc_tag,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  input  logic             squash,
  input  logic [PTR_W-1:0] squash_tag,
  input  logic             head_ready,
  input  logic             head_is_load,
  output logic [PTR_W-1:0] head_tag,
  output logic             head_done,
  input  logic             retire,
  output logic             dmem_req,
  output logic             dmem_read,
  input  logic             dmem_resp,
  output logic [DEPTH-1:0] issue_we,
  output logic [DEPTH-1:0] issue_clr,
  output logic [DEPTH-1:0] issue_ld_mem_val
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} mem_state_t;

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   ONE_CNT  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

  mem_state_t       state;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   cnt;
  logic             req_q;
  logic             read_q;
  logic [PTR_W-1:0] keep_off;
  logic [PTR_W-1:0] offs;
  logic             retire_ok;
  logic             alloc_ok;

  assign count     = cnt;
  assign full      = (cnt == FULL_CNT);
  assign empty     = (cnt == '0);
  assign head_tag  = head;
  assign alloc_tag = tail;
  assign head_done = (state == DONE);
  assign dmem_req  = req_q;
  assign dmem_read = req_q & read_q;

  // flush and squash both mask normal alloc/retire for the cycle
  assign retire_ok = ~flush & ~squash & retire & head_done;
  assign alloc_ok  = ~flush & ~squash & alloc & (~full | retire_ok);

  // distance from head to the youngest surviving entry
  assign keep_off = squash_tag - head;

  always_comb begin
    issue_we         = '0;
    issue_clr        = '0;
    issue_ld_mem_val = '0;
    offs             = '0;
    if (!flush) begin
      if (squash) begin
        // clear occupied entries whose age offset lies beyond the survivor
        for (int i = 0; i < DEPTH; i++) begin
          offs = PTR_W'(i) - head;
          if ((offs > keep_off) && ({1'b0, offs} < cnt))
            issue_clr[i] = 1'b1;
        end
      end else begin
        if (alloc_ok)  issue_we[tail]  = 1'b1;
        if (retire_ok) issue_clr[head] = 1'b1;
      end
      if (state == REQ && dmem_resp)
        issue_ld_mem_val[head] = dmem_read;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (squash) begin
      tail <= squash_tag + ONE_PTR;
      cnt  <= {1'b0, keep_off} + ONE_CNT;
    end else begin
      if (alloc_ok)  tail <= tail + ONE_PTR;
      if (retire_ok) head <= head + ONE_PTR;
      if (alloc_ok && !retire_ok)      cnt <= cnt + ONE_CNT;
      else if (!alloc_ok && retire_ok) cnt <= cnt - ONE_CNT;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      // an access already on the bus must be allowed to complete
      if (state == REQ || state == DRAIN) begin
        state <= DRAIN;
        req_q <= 1'b1;
      end else begin
        state <= IDLE;
        req_q <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: if (!empty && head_ready) begin
          state  <= REQ;
          req_q  <= 1'b1;
          read_q <= head_is_load;
        end
        REQ: if (dmem_resp) begin
          state <= DONE;
          req_q <= 1'b0;
        end
        DONE: if (retire_ok) state <= IDLE;
        DRAIN: if (dmem_resp) begin
          state <= IDLE;
          req_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldstr_queue_ctrl.sv
// Directed testbench for ldstr_queue_ctrl (DEPTH = 8).
// Inputs change 1 ns after the rising edge. Same-cycle strobes are sampled
// 2 ns after the edge, and registered state is sampled 1 ns after the edge.
module tb_ldstr_queue_ctrl;

  logic       clk = 1'b0;
  logic       flush, alloc, squash, head_ready, head_is_load, retire, dmem_resp;
  logic [2:0] squash_tag;
  logic [2:0] alloc_tag, head_tag;
  logic       full, empty, head_done, dmem_req, dmem_read;
  logic [3:0] count;
  logic [7:0] issue_we, issue_clr, issue_ld_mem_val;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ldstr_queue_ctrl #(.DEPTH(8)) dut (
    .clk(clk), .flush(flush), .alloc(alloc), .alloc_tag(alloc_tag),
    .full(full), .empty(empty), .count(count), .squash(squash),
    .squash_tag(squash_tag), .head_ready(head_ready), .head_is_load(head_is_load),
    .head_tag(head_tag), .head_done(head_done), .retire(retire),
    .dmem_req(dmem_req), .dmem_read(dmem_read), .dmem_resp(dmem_resp),
    .issue_we(issue_we), .issue_clr(issue_clr), .issue_ld_mem_val(issue_ld_mem_val)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // store handshake on the head entry, then retire it
  task automatic do_retire();
    head_ready = 1'b1; head_is_load = 1'b0;
    tick();
    head_ready = 1'b0; dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0; retire = 1'b1;
    tick();
    retire = 1'b0;
  endtask

  initial begin
    flush = 1'b1; alloc = 1'b0; squash = 1'b0; squash_tag = '0;
    head_ready = 1'b0; head_is_load = 1'b0; retire = 1'b0; dmem_resp = 1'b0;
    #1;
    tick(); tick();
    flush = 1'b0; dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;

    // reset state
    chk_val("rst_count", count, 0);
    chk_val("rst_empty", empty, 1);
    chk_val("rst_full", full, 0);
    chk_val("rst_head", head_tag, 0);
    chk_val("rst_tail", alloc_tag, 0);
    chk_val("rst_req", dmem_req, 0);

    // fill to full
    for (int i = 0; i < 8; i++) begin
      alloc = 1'b1;
      #1;
      chk_val("fill_we", issue_we, 32'(1) << i);
      chk_val("fill_tag", alloc_tag, i);
      tick();
    end
    chk_val("fill_full", full, 1);
    chk_val("fill_count", count, 8);
    #1;
    chk_val("ninth_we", issue_we, 0);
    tick();
    alloc = 1'b0;
    chk_val("ninth_tail", alloc_tag, 0);
    chk_val("ninth_count", count, 8);

    // head store request, early retire ignored, then pass-through alloc/retire
    head_ready = 1'b1; head_is_load = 1'b0;
    tick();
    head_ready = 1'b0;
    chk_val("st_req", dmem_req, 1);
    chk_val("st_read", dmem_read, 0);
    retire = 1'b1;
    #1;
    chk_val("early_ret_clr", issue_clr, 0);
    tick();
    retire = 1'b0;
    chk_val("early_ret_head", head_tag, 0);
    chk_val("early_ret_count", count, 8);
    chk_val("early_ret_req", dmem_req, 1);
    dmem_resp = 1'b1;
    #1;
    chk_val("st_ldval", issue_ld_mem_val, 0);
    tick();
    dmem_resp = 1'b0;
    chk_val("st_done", head_done, 1);
    chk_val("st_req_off", dmem_req, 0);
    alloc = 1'b1; retire = 1'b1;
    #1;
    chk_val("pt_we", issue_we, 8'h01);
    chk_val("pt_clr", issue_clr, 8'h01);
    tick();
    alloc = 1'b0; retire = 1'b0;
    chk_val("pt_count", count, 8);
    chk_val("pt_head", head_tag, 1);
    chk_val("pt_tail", alloc_tag, 1);

    // load handshake with three wait cycles
    do_flush();
    chk_val("fl_count", count, 0);
    alloc = 1'b1; head_ready = 1'b1; head_is_load = 1'b1;
    tick();
    alloc = 1'b0;
    chk_val("ld_count", count, 1);
    chk_val("ld_req_t1", dmem_req, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk_val("ld_req_wait", dmem_req, 1);
      chk_val("ld_read_wait", dmem_read, 1);
      #1;
      chk_val("ld_ldval_wait", issue_ld_mem_val, 0);
      tick();
    end
    dmem_resp = 1'b1;
    #1;
    chk_val("ld_req_resp", dmem_req, 1);
    chk_val("ld_ldval", issue_ld_mem_val, 8'h01);
    tick();
    dmem_resp = 1'b0; head_ready = 1'b0;
    chk_val("ld_done", head_done, 1);
    chk_val("ld_req_off", dmem_req, 0);
    retire = 1'b1;
    #1;
    chk_val("ld_ret_clr", issue_clr, 8'h01);
    tick();
    retire = 1'b0;
    chk_val("ld_empty", empty, 1);
    chk_val("ld_head", head_tag, 1);
    chk_val("ld_done_off", head_done, 0);

    // squash: head 2, tags 2..7 occupied, keep up to tag 4
    do_flush();
    alloc = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    alloc = 1'b0;
    do_retire();
    do_retire();
    chk_val("sq_pre_head", head_tag, 2);
    chk_val("sq_pre_count", count, 6);
    squash = 1'b1; squash_tag = 3'd4; alloc = 1'b1;
    #1;
    chk_val("sq_clr", issue_clr, 8'hE0);
    chk_val("sq_we", issue_we, 0);
    tick();
    squash = 1'b0; alloc = 1'b0;
    chk_val("sq_tail", alloc_tag, 5);
    chk_val("sq_count", count, 3);
    chk_val("sq_head", head_tag, 2);

    // flush while a load request is outstanding
    head_ready = 1'b1; head_is_load = 1'b1;
    tick();
    head_ready = 1'b0;
    chk_val("fr_req", dmem_req, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_val("fr_count", count, 0);
    chk_val("fr_drain_req", dmem_req, 1);
    chk_val("fr_drain_read", dmem_read, 1);
    alloc = 1'b1;
    #1;
    chk_val("fr_drain_we", issue_we, 8'h01);
    tick();
    alloc = 1'b0;
    chk_val("fr_drain_count", count, 1);
    chk_val("fr_drain_req2", dmem_req, 1);
    dmem_resp = 1'b1;
    #1;
    chk_val("fr_ldval", issue_ld_mem_val, 0);
    tick();
    dmem_resp = 1'b0;
    chk_val("fr_req_off", dmem_req, 0);
    chk_val("fr_done", head_done, 0);
    head_ready = 1'b1;
    tick();
    head_ready = 1'b0;
    chk_val("fr_idle_req", dmem_req, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
